reset_sequencer: RTL

Central reset controller for the processor/UART system. It takes the synchronized system reset plus soft-reset and watchdog requests, holds all downstream domains in reset, then releases them one at a time in a fixed order with programmable spacing. It sits directly after the system reset synchronizer and drives the per-domain active-low resets, for example bus fabric, then processor core, then UART.

---
 rtl/reset_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Central reset sequencer: holds every downstream domain in reset after a
// power-on, software or watchdog reset event, then releases the domains one
// at a time in index order with a programmable spacing between releases.
module reset_sequencer #(
   parameter int N_DOMAINS   = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sw_reset_req,
   input  logic                 wdt_expire,
   output logic [N_DOMAINS-1:0] rst_n_out,
   output logic                 seq_done,
   output logic [1:0]           reset_cause
);

   localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;
   localparam logic [1:0] CAUSE_WDT = 2'b11;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [IDX_W-1:0]     idx, idx_nx;
   logic [N_DOMAINS-1:0] rst_nx;
   logic                 done_nx;
   logic [1:0]           cause_nx;

   // State, counters and every output are registered so no input reaches an
   // output combinationally.
   // NOTE: sequential state uses non-blocking (<=) so all registers update
   // together from pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_HOLD;
         cnt         <= '0;
         idx         <= '0;
         rst_n_out   <= '0;
         seq_done    <= 1'b0;
         reset_cause <= CAUSE_POR;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         idx         <= idx_nx;
         rst_n_out   <= rst_nx;
         seq_done    <= done_nx;
         reset_cause <= cause_nx;
      end
   end

   // Next-state logic: a request always wins over a scheduled release.
   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      rst_nx   = rst_n_out;
      done_nx  = seq_done;
      cause_nx = reset_cause;

      if (wdt_expire || sw_reset_req) begin
         state_nx = S_HOLD;
         cnt_nx   = '0;
         idx_nx   = '0;
         rst_nx   = '0;
         done_nx  = 1'b0;
         cause_nx = wdt_expire ? CAUSE_WDT : CAUSE_SW;
      end else begin
         case (state)
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt_nx    = '0;
                  rst_nx[0] = 1'b1;
                  if (N_DOMAINS == 1) begin
                     state_nx = S_RUN;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx = S_RELEASE;
                     idx_nx   = IDX_W'(1);
                  end
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (cnt == GAP_LAST) begin
                  cnt_nx      = '0;
                  rst_nx[idx] = 1'b1;
                  if (idx == IDX_LAST) begin
                     state_nx = S_RUN;
                     done_nx  = 1'b1;
                  end else begin
                     idx_nx = idx + IDX_W'(1);
                  end
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               // Outputs hold until a reset event.
            end
            default: begin
               state_nx = S_HOLD;
            end
         endcase
      end
   end

endmodule
